// File: rtl/amdemod_pkg.sv
// Shared constants and types for the AM demodulator tuning sequencer.
package amdemod_pkg;

  // Demod register map
  localparam logic [1:0] DM_GAIN    = 2'd0;
  localparam logic [1:0] DM_PLL     = 2'd1;
  localparam logic [1:0] DM_FILTER  = 2'd2;
  localparam logic [1:0] DM_LGCOEFF = 2'd3;

  localparam int unsigned FILTER_RESET_BIT = 31;
  localparam int unsigned DM_DW            = 32;

  // Host register map
  localparam logic [1:0] HR_CTRL      = 2'd0;
  localparam logic [1:0] HR_BASE_STEP = 2'd1;
  localparam logic [1:0] HR_STEP_INC  = 2'd2;
  localparam logic [1:0] HR_TIMEOUT   = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RST_FIL = 4'd1,
    ST_COEF    = 4'd2,
    ST_LGC     = 4'd3,
    ST_STEP    = 4'd4,
    ST_WAIT    = 4'd5,
    ST_LOCKED  = 4'd6,
    ST_FAIL    = 4'd7
  } seq_state_t;

  // One demod bus write
  typedef struct packed {
    logic [1:0]       addr;
    logic [DM_DW-1:0] data;
  } dm_wr_t;

endpackage

// File: rtl/amdemod_bus_wr.sv
// Single-outstanding write master for the demod bus: holds stb until ack.
module amdemod_bus_wr
  import amdemod_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             req,
  input  logic [1:0]       req_addr,
  input  logic [DM_DW-1:0] req_data,
  input  logic             ack,
  output logic             stb,
  output logic [1:0]       bus_addr,
  output logic [DM_DW-1:0] bus_data,
  output logic             done_c
);

  // Latch a request when idle; drop strobe on the acking cycle
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stb      <= 1'b0;
      bus_addr <= '0;
      bus_data <= '0;
    end else if (stb) begin
      if (ack) stb <= 1'b0;
    end else if (req) begin
      stb      <= 1'b1;
      bus_addr <= req_addr;
      bus_data <= req_data;
    end
  end

  // Acks with nothing outstanding never complete a write
  assign done_c = stb & ack;

endmodule

// File: rtl/amdemod_tune_seq.sv
// Configuration sequencer: filter reload, PLL loop coefficient, step sweep until lock.
module amdemod_tune_seq
  import amdemod_pkg::*;
#(
  parameter int unsigned NCOEFFS   = 666,
  parameter int unsigned NSWEEP    = 16,
  parameter int unsigned LOCK_HOLD = 1024,
  parameter int unsigned PLL_PHASE = 20,
  localparam int unsigned CA = (NCOEFFS > 1) ? $clog2(NCOEFFS) : 1
)(
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [1:0]    i_wb_addr,
  input  logic [31:0]   i_wb_data,
  input  logic [3:0]    i_wb_sel,
  output logic          o_wb_stall,
  output logic          o_wb_ack,
  output logic [31:0]   o_wb_data,
  output logic [CA-1:0] o_coef_addr,
  input  logic [15:0]   i_coef_data,
  output logic          o_dm_stb,
  output logic [1:0]    o_dm_addr,
  output logic [31:0]   o_dm_data,
  input  logic          i_dm_ack,
  input  logic          i_pll_locked,
  output logic          o_busy,
  output logic          o_locked
);

  localparam int unsigned SW = PLL_PHASE - 1;
  localparam int unsigned KW = (NSWEEP > 1) ? $clog2(NSWEEP) : 1;
  localparam int unsigned HW = $clog2(LOCK_HOLD + 1);
  localparam int unsigned PAD = 32 - PLL_PHASE;

  // Host-visible shadow registers
  logic [SW-1:0] base_step_r, step_inc_r;
  logic [31:0]   timeout_r;
  logic [4:0]    lgcoeff_r;

  // Sequencer state
  seq_state_t    state;
  logic [KW-1:0] k;
  logic [SW-1:0] step_acc, step_inc_a;
  logic [31:0]   timeout_a, timer;
  logic [HW-1:0] hold;
  logic          coef_wait, wr_issued, wr_req, abort_pend, fail_r;
  dm_wr_t        wr_pay;

  logic          wr_done_c, host_wr_c, start_c, abort_c, seq_idle_c;
  logic [31:0]   rd_mux_c, timer_nx_c;
  logic [HW-1:0] hold_nx_c;
  logic          unused_sel;

  assign o_wb_stall = 1'b0;
  assign unused_sel = ^i_wb_sel;

  assign host_wr_c  = i_wb_cyc & i_wb_stb & i_wb_we;
  assign abort_c    = host_wr_c & (i_wb_addr == HR_CTRL) & i_wb_data[1];
  assign start_c    = host_wr_c & (i_wb_addr == HR_CTRL) & i_wb_data[0] & ~i_wb_data[1];
  assign seq_idle_c = (state == ST_IDLE) | (state == ST_LOCKED) | (state == ST_FAIL);

  // Readback mux and WAIT-state counter increments
  always_comb begin
    rd_mux_c   = '0;
    timer_nx_c = timer + 32'd1;
    hold_nx_c  = i_pll_locked ? hold + HW'(1) : '0;
    case (i_wb_addr)
      HR_CTRL:      rd_mux_c = {16'h0, fail_r, o_locked, o_busy, 5'h0, state, 4'(k)};
      HR_BASE_STEP: rd_mux_c = 32'(base_step_r);
      HR_STEP_INC:  rd_mux_c = 32'(step_inc_r);
      default:      rd_mux_c = timeout_r;
    endcase
  end

  // Host register writes and single-cycle-latency acks
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      base_step_r <= SW'(32'h0000_4000);
      step_inc_r  <= SW'(32'h0000_0400);
      timeout_r   <= 32'd1_000_000;
      lgcoeff_r   <= 5'd2;
      o_wb_ack    <= 1'b0;
      o_wb_data   <= '0;
    end else begin
      o_wb_ack <= i_wb_cyc & i_wb_stb;
      if (i_wb_cyc && i_wb_stb && !i_wb_we) o_wb_data <= rd_mux_c;
      if (host_wr_c) begin
        case (i_wb_addr)
          HR_CTRL:      lgcoeff_r   <= i_wb_data[12:8];
          HR_BASE_STEP: base_step_r <= SW'(i_wb_data);
          HR_STEP_INC:  step_inc_r  <= SW'(i_wb_data);
          default:      timeout_r   <= i_wb_data;
        endcase
      end
    end
  end

  // Sequencer FSM; abort drains any outstanding demod write before IDLE
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= ST_IDLE;
      k           <= '0;
      step_acc    <= '0;
      step_inc_a  <= '0;
      timeout_a   <= 32'd1;
      timer       <= '0;
      hold        <= '0;
      coef_wait   <= 1'b0;
      wr_issued   <= 1'b0;
      wr_req      <= 1'b0;
      wr_pay      <= '0;
      abort_pend  <= 1'b0;
      fail_r      <= 1'b0;
      o_locked    <= 1'b0;
      o_busy      <= 1'b0;
      o_coef_addr <= '0;
    end else begin
      wr_req <= 1'b0;
      if (abort_c) begin
        abort_pend <= 1'b1;
        o_locked   <= 1'b0;
        fail_r     <= 1'b0;
      end
      if (abort_pend) begin
        if (!wr_issued || wr_done_c) begin
          state      <= ST_IDLE;
          abort_pend <= 1'b0;
          wr_issued  <= 1'b0;
          o_busy     <= 1'b0;
        end
      end else begin
        case (state)
          ST_RST_FIL: begin
            if (!wr_issued) begin
              wr_req      <= 1'b1;
              wr_pay.addr <= DM_FILTER;
              wr_pay.data <= 32'(1) << FILTER_RESET_BIT;
              wr_issued   <= 1'b1;
            end else if (wr_done_c) begin
              wr_issued   <= 1'b0;
              o_coef_addr <= '0;
              coef_wait   <= 1'b0;
              state       <= ST_COEF;
            end
          end
          ST_COEF: begin
            // Memory data lands one cycle after the address, so wait a cycle first
            if (!wr_issued) begin
              if (coef_wait) begin
                wr_req      <= 1'b1;
                wr_pay.addr <= DM_FILTER;
                wr_pay.data <= {16'h0, i_coef_data};
                wr_issued   <= 1'b1;
                coef_wait   <= 1'b0;
              end else begin
                coef_wait <= 1'b1;
              end
            end else if (wr_done_c) begin
              wr_issued <= 1'b0;
              if (o_coef_addr == CA'(NCOEFFS - 1)) state <= ST_LGC;
              else o_coef_addr <= o_coef_addr + CA'(1);
            end
          end
          ST_LGC: begin
            if (!wr_issued) begin
              wr_req      <= 1'b1;
              wr_pay.addr <= DM_LGCOEFF;
              wr_pay.data <= {27'h0, lgcoeff_r};
              wr_issued   <= 1'b1;
            end else if (wr_done_c) begin
              wr_issued <= 1'b0;
              state     <= ST_STEP;
            end
          end
          ST_STEP: begin
            if (!wr_issued) begin
              wr_req      <= 1'b1;
              wr_pay.addr <= DM_PLL;
              wr_pay.data <= {1'b0, step_acc, {PAD{1'b0}}};
              wr_issued   <= 1'b1;
            end else if (wr_done_c) begin
              wr_issued <= 1'b0;
              timer     <= '0;
              hold      <= '0;
              state     <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            timer <= timer_nx_c;
            hold  <= hold_nx_c;
            // Lock takes priority over a simultaneous timeout
            if (hold_nx_c == HW'(LOCK_HOLD)) begin
              state    <= ST_LOCKED;
              o_locked <= 1'b1;
              o_busy   <= 1'b0;
            end else if (timer_nx_c == timeout_a) begin
              if (k == KW'(NSWEEP - 1)) begin
                state  <= ST_FAIL;
                fail_r <= 1'b1;
                o_busy <= 1'b0;
              end else begin
                k        <= k + KW'(1);
                step_acc <= step_acc + step_inc_a;
                state    <= ST_STEP;
              end
            end
          end
          default: ;
        endcase
        if (start_c && seq_idle_c) begin
          state       <= ST_RST_FIL;
          o_busy      <= 1'b1;
          o_locked    <= 1'b0;
          fail_r      <= 1'b0;
          k           <= '0;
          step_acc    <= base_step_r;
          step_inc_a  <= step_inc_r;
          timeout_a   <= (timeout_r == 32'd0) ? 32'd1 : timeout_r;
          o_coef_addr <= '0;
          coef_wait   <= 1'b0;
          wr_issued   <= 1'b0;
        end
      end
    end
  end

  amdemod_bus_wr u_bus_wr (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .req       (wr_req),
    .req_addr  (wr_pay.addr),
    .req_data  (wr_pay.data),
    .ack       (i_dm_ack),
    .stb       (o_dm_stb),
    .bus_addr  (o_dm_addr),
    .bus_data  (o_dm_data),
    .done_c    (wr_done_c)
  );

endmodule

// File: tb/tb_amdemod_tune_seq.sv
// Scoreboard bench for the tuning sequencer with a small demod/coef-memory model.
module tb_amdemod_tune_seq;

  localparam int unsigned NCOEFFS   = 16;
  localparam int unsigned NSWEEP    = 4;
  localparam int unsigned LOCK_HOLD = 1024;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_wb_cyc, i_wb_stb, i_wb_we;
  logic [1:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic [3:0]  i_wb_sel;
  logic        o_wb_stall, o_wb_ack;
  logic [31:0] o_wb_data;
  logic [3:0]  o_coef_addr;
  logic [15:0] i_coef_data;
  logic        o_dm_stb;
  logic [1:0]  o_dm_addr;
  logic [31:0] o_dm_data;
  logic        i_dm_ack;
  logic        i_pll_locked;
  logic        o_busy, o_locked;

  amdemod_tune_seq #(.NCOEFFS(NCOEFFS), .NSWEEP(NSWEEP), .LOCK_HOLD(LOCK_HOLD), .PLL_PHASE(20)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
    .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
    .o_coef_addr(o_coef_addr), .i_coef_data(i_coef_data),
    .o_dm_stb(o_dm_stb), .o_dm_addr(o_dm_addr), .o_dm_data(o_dm_data), .i_dm_ack(i_dm_ack),
    .i_pll_locked(i_pll_locked), .o_busy(o_busy), .o_locked(o_locked)
  );

  always #5 i_clk = ~i_clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc_cnt = 0;
  int          step_cyc = 0;
  int          n_unexp = 0;
  int          stb_drop_err = 0;
  int          ack_delay = 0;
  int          ack_cnt = 0;
  int          lock_mode = 0;
  int          pat_cnt = 0;
  logic        locked_seen = 1'b0;
  logic        stb_prev = 1'b0, ack_prev = 1'b0;
  logic [15:0] cmem [16];
  logic [15:0] coef_q;
  logic [33:0] exp_q [$];
  logic [33:0] sb_e;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp_v);
    end
  endtask

  // Coefficient memory: synchronous read, data valid the cycle after the address
  always @(posedge i_clk) coef_q <= cmem[o_coef_addr];
  assign i_coef_data = coef_q;

  // Demod slave: ack after ack_delay extra cycles, one-cycle pulse
  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      i_dm_ack <= 1'b0;
      ack_cnt  <= 0;
    end else if (i_dm_ack) begin
      i_dm_ack <= 1'b0;
      ack_cnt  <= 0;
    end else if (o_dm_stb) begin
      if (ack_cnt >= ack_delay) i_dm_ack <= 1'b1;
      else ack_cnt <= ack_cnt + 1;
    end
  end

  always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

  // Lock flag source: low, high, or 500-high/1-low pattern
  initial begin
    i_pll_locked = 1'b0;
    forever begin
      @(negedge i_clk);
      case (lock_mode)
        0: i_pll_locked = 1'b0;
        1: i_pll_locked = 1'b1;
        default: begin
          if (pat_cnt == 500) begin i_pll_locked = 1'b0; pat_cnt = 0; end
          else begin i_pll_locked = 1'b1; pat_cnt++; end
        end
      endcase
    end
  end

  // Monitor: compare every accepted demod write against the scoreboard
  always @(negedge i_clk) begin
    if (i_reset_n) begin
      if (o_locked) locked_seen = 1'b1;
      if (stb_prev && !ack_prev && !o_dm_stb) stb_drop_err++;
      if (o_dm_stb && i_dm_ack) begin
        if (exp_q.size() == 0) n_unexp++;
        else begin
          sb_e = exp_q.pop_front();
          chk("dm_wr", 64'({o_dm_addr, o_dm_data}), 64'(sb_e));
        end
        if (o_dm_addr == 2'd1) step_cyc = cyc_cnt;
      end
    end
    stb_prev = o_dm_stb;
    ack_prev = i_dm_ack;
  end

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge i_clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_addr = a; i_wb_data = d;
    @(negedge i_clk);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
  endtask

  task automatic wb_read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp_v);
    @(negedge i_clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = a;
    @(negedge i_clk);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    chk({tag, "_ack"}, 64'(o_wb_ack), 64'd1);
    chk(tag, 64'(o_wb_data), 64'(exp_v));
  endtask

  task automatic push_prefix();
    exp_q.push_back({2'd2, 32'h8000_0000});
    for (int i = 0; i < NCOEFFS; i++) exp_q.push_back({2'd2, 16'h0, cmem[i]});
    exp_q.push_back({2'd3, 32'd2});
  endtask

  task automatic push_step(input logic [18:0] s);
    exp_q.push_back({2'd1, 1'b0, s, 12'h000});
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (o_busy && n < bound) begin @(negedge i_clk); n++; end
    chk(tag, 64'(o_busy), 64'd0);
  endtask

  task automatic end_of_test(input string tag);
    repeat (20) @(negedge i_clk);
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_no_extra"}, 64'(n_unexp), 64'd0);
    exp_q.delete();
    n_unexp = 0;
  endtask

  initial begin
    int n;
    int lat;
    i_reset_n = 1'b0;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    i_wb_addr = 2'd0; i_wb_data = '0; i_wb_sel = 4'hF;
    for (int i = 0; i < 16; i++) cmem[i] = 16'($urandom);
    repeat (3) @(negedge i_clk);
    chk("rst_outs", 64'({o_busy, o_locked, o_dm_stb, o_wb_ack, o_coef_addr}), 64'd0);
    i_reset_n = 1'b1;
    wb_read_chk("rst_ctrl", 2'd0, 32'h0);
    wb_read_chk("rst_base", 2'd1, 32'h0000_4000);
    wb_read_chk("rst_inc",  2'd2, 32'h0000_0400);
    wb_read_chk("rst_tmo",  2'd3, 32'd1_000_000);

    // 1: lock held high -> full load then lock after LOCK_HOLD cycles in WAIT
    lock_mode = 1;
    push_prefix();
    push_step(19'h04000);
    wb_write(2'd0, 32'h0000_0201);
    chk("t1_busy", 64'(o_busy), 64'd1);
    n = 0;
    while (!o_locked && n < 3000) begin @(negedge i_clk); n++; end
    lat = cyc_cnt - step_cyc;
    chk("t1_locked", 64'(o_locked), 64'd1);
    chk("t1_lock_lat", 64'(lat), 64'(LOCK_HOLD + 1));
    chk("t1_busy_low", 64'(o_busy), 64'd0);
    wb_read_chk("t1_ctrl", 2'd0, 32'h0000_4060);
    lock_mode = 0;
    repeat (5) @(negedge i_clk);
    chk("t1_lock_sticky", 64'(o_locked), 64'd1);
    end_of_test("t1");

    // 2: never locks -> four steps then FAIL
    wb_write(2'd3, 32'd100);
    push_prefix();
    push_step(19'h04000); push_step(19'h04400); push_step(19'h04800); push_step(19'h04C00);
    wb_write(2'd0, 32'h0000_0201);
    chk("t2_busy", 64'(o_busy), 64'd1);
    chk("t2_lock_clr", 64'(o_locked), 64'd0);
    wait_idle("t2_idle", 3000);
    wb_read_chk("t2_ctrl", 2'd0, 32'h0000_8073);
    end_of_test("t2");

    // 3: lock drops for one cycle every 500 -> hold never reaches LOCK_HOLD
    wb_write(2'd3, 32'd2000);
    lock_mode = 2; pat_cnt = 0;
    locked_seen = 1'b0;
    push_prefix();
    push_step(19'h04000); push_step(19'h04400); push_step(19'h04800); push_step(19'h04C00);
    wb_write(2'd0, 32'h0000_0201);
    wait_idle("t3_idle", 12000);
    chk("t3_no_lock", 64'(locked_seen), 64'd0);
    wb_read_chk("t3_ctrl", 2'd0, 32'h0000_8073);
    lock_mode = 0;
    end_of_test("t3");

    // 4: abort mid-COEF while a slow-acked write is outstanding
    ack_delay = 5;
    stb_drop_err = 0;
    exp_q.push_back({2'd2, 32'h8000_0000});
    for (int i = 0; i < 4; i++) exp_q.push_back({2'd2, 16'h0, cmem[i]});
    wb_write(2'd0, 32'h0000_0201);
    n = 0;
    while (!(o_dm_stb && o_coef_addr == 4'd3) && n < 500) begin @(negedge i_clk); n++; end
    chk("t4_reach_coef3", 64'(o_dm_stb && o_coef_addr == 4'd3), 64'd1);
    wb_write(2'd0, 32'h0000_0002);
    chk("t4_stb_held", 64'(o_dm_stb), 64'd1);
    wait_idle("t4_idle", 100);
    repeat (100) @(negedge i_clk);
    chk("t4_stb_drop", 64'(stb_drop_err), 64'd0);
    wb_read_chk("t4_ctrl", 2'd0, 32'h0);
    end_of_test("t4");
    ack_delay = 0;

    // 5: async reset while in WAIT
    push_prefix();
    push_step(19'h04000);
    wb_write(2'd0, 32'h0000_0201);
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin @(negedge i_clk); n++; end
    chk("t5_drained", 64'(exp_q.size()), 64'd0);
    wb_read_chk("t5_ctrl_wait", 2'd0, 32'h0000_2050);
    @(posedge i_clk);
    #2 i_reset_n = 1'b0;
    #1;
    chk("t5_rst_ctl", 64'({o_busy, o_locked, o_dm_stb, o_wb_ack, o_coef_addr, o_dm_addr}), 64'd0);
    chk("t5_rst_data", 64'({o_dm_data, o_wb_data}), 64'd0);
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    wb_read_chk("t5_tmo", 2'd3, 32'd1_000_000);
    wb_read_chk("t5_ctrl", 2'd0, 32'h0);
    end_of_test("t5");

    // 6: step accumulator wraps modulo 2^19
    wb_write(2'd1, 32'h0007_FC00);
    wb_write(2'd2, 32'h0000_0800);
    wb_write(2'd3, 32'd10);
    push_prefix();
    push_step(19'h7FC00); push_step(19'h00400); push_step(19'h00C00); push_step(19'h01400);
    wb_write(2'd0, 32'h0000_0201);
    wait_idle("t6_idle", 2000);
    wb_read_chk("t6_ctrl", 2'd0, 32'h0000_8073);
    end_of_test("t6");

    chk("stall_zero", 64'(o_wb_stall), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
